aes: RTL and testbench

AES -- requirements
Module: aes

---
 rtl/aes.sv | 227 ++++++++++++++++++++++
 tb/tb_aes.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/aes.sv
// aes: AES-128 decryption core (FIPS-197 inverse cipher) with a serial load/unload port.
// Keys are expanded forward to round key 10, then unwound one round per cycle during decrypt.
// Optional AES_LOAD_SYNC_EN: routes load through a two-flop clk-domain synchronizer.
module aes (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic sdi,
  input  logic load,
  output logic sdo,
  output logic done
);

  typedef enum logic [1:0] {StIdle, StExpand, StDecrypt, StDone} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return ginv(y);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:  return 8'h01;
      4'd2:  return 8'h02;
      4'd3:  return 8'h04;
      4'd4:  return 8'h08;
      4'd5:  return 8'h10;
      4'd6:  return 8'h20;
      4'd7:  return 8'h40;
      4'd8:  return 8'h80;
      4'd9:  return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   key_q, key_d, st_q, st_d, pt_q, pt_d;
  logic           done_q, done_d, load_prev_q, load_c;
  logic [255:0]   in_q;
  logic [7:0]     ocnt_q;
  logic [31:0]    ks_in, ks_tmp;
  logic [127:0]   key_fwd, key_inv, isr, ark, imc;

`ifdef AES_LOAD_SYNC_EN
  logic load_s1_q, load_s2_q;
  // Two-flop synchronizer for the host-driven load level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_s1_q <= 1'b0;
      load_s2_q <= 1'b0;
    end else begin
      load_s1_q <= load;
      load_s2_q <= load_s1_q;
    end
  end
  assign load_c = load_s2_q;
`else
  assign load_c = load;
`endif

  // Input shift register lives in the sck domain and is deliberately not reset.
  always_ff @(posedge sck) begin
    if (load) in_q <= {in_q[254:0], sdi};
  end

  // Key schedule step: shares four S-boxes between forward and inverse directions.
  always_comb begin
    ks_in  = (state_q == StExpand) ? key_q[31:0] : (key_q[31:0] ^ key_q[63:32]);
    ks_tmp = {sbox(ks_in[23:16]), sbox(ks_in[15:8]), sbox(ks_in[7:0]), sbox(ks_in[31:24])};
    ks_tmp[31:24] = ks_tmp[31:24] ^ ((state_q == StExpand) ? rcon(4'(cnt_q + 4'd1))
                                                            : rcon(4'(4'd10 - cnt_q)));
    key_fwd[127:96] = key_q[127:96] ^ ks_tmp;
    key_fwd[95:64]  = key_q[95:64] ^ key_fwd[127:96];
    key_fwd[63:32]  = key_q[63:32] ^ key_fwd[95:64];
    key_fwd[31:0]   = key_q[31:0] ^ key_fwd[63:32];
    key_inv[127:96] = key_q[127:96] ^ ks_tmp;
    key_inv[95:64]  = key_q[95:64] ^ key_q[127:96];
    key_inv[63:32]  = key_q[63:32] ^ key_q[95:64];
    key_inv[31:0]   = key_q[31:0] ^ key_q[63:32];
  end

  // Inverse round datapath: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
  always_comb begin
    isr = '0;
    for (int i = 0; i < 16; i++) begin
      isr[8*(15-i) +: 8] = st_q[8*(15 - (4*(((i/4) - (i%4)) & 3) + (i%4))) +: 8];
    end
    for (int i = 0; i < 16; i++) begin
      ark[8*i +: 8] = inv_sbox(isr[8*i +: 8]) ^ key_q[8*i +: 8];
    end
    for (int c = 0; c < 4; c++) begin
      imc[32*c +: 32] = inv_mix_col(ark[32*c +: 32]);
    end
  end

  // Sequencer: load aborts from any state; the falling level of load starts a run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    st_d    = st_q;
    pt_d    = pt_q;
    done_d  = done_q;
    if (load_c) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_prev_q) begin
            state_d = StExpand;
            cnt_d   = 4'd0;
            st_d    = in_q[255:128];
            key_d   = in_q[127:0];
          end
        end
        StExpand: begin
          key_d = key_fwd;
          cnt_d = 4'(cnt_q + 4'd1);
          if (cnt_q == 4'd9) begin
            state_d = StDecrypt;
            cnt_d   = 4'd0;
          end
        end
        StDecrypt: begin
          key_d = key_inv;
          cnt_d = 4'(cnt_q + 4'd1);
          if (cnt_q == 4'd0) begin
            st_d = st_q ^ key_q;
          end else if (cnt_q == 4'd10) begin
            pt_d    = ark;
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            st_d = imc;
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  // Core state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      key_q       <= '0;
      st_q        <= '0;
      pt_q        <= '0;
      done_q      <= 1'b0;
      load_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      st_q        <= st_d;
      pt_q        <= pt_d;
      done_q      <= done_d;
      load_prev_q <= load_c;
    end
  end

  // Unload position counter in the sck domain; equivalent to shifting the output register
  // left with zero fill, and held clear whenever done is low.
  always_ff @(negedge sck or negedge done_q) begin
    if (!done_q) begin
      ocnt_q <= 8'd0;
    end else if (!load && !ocnt_q[7]) begin
      ocnt_q <= 8'(ocnt_q + 8'd1);
    end
  end

  logic [6:0] obit;
  assign obit = ~ocnt_q[6:0];
  assign sdo  = ocnt_q[7] ? 1'b0 : pt_q[obit];
  assign done = done_q;

endmodule

// File: tb/tb_aes.sv
// tb_aes: directed-vector bench for the aes decryption core.
module tb_aes;

  logic clk = 1'b0;
  logic reset, sck, sdi, load;
  logic sdo, done;
  int   checks = 0;
  int   errors = 0;

  localparam logic [127:0] Key1 = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] Ct1  = 128'h3925841D02DC09FBDC118597196A0B32;
  localparam logic [127:0] Pt1  = 128'h3243F6A8885A308D313198A2E0370734;
  localparam logic [127:0] Key2 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] Ct2  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
  localparam logic [127:0] Pt2  = 128'h00112233445566778899AABBCCDDEEFF;

  // Edges counted from the first clk edge that sees load low (that edge is number 1).
`ifdef AES_LOAD_SYNC_EN
  localparam int Latency = 24;
`else
  localparam int Latency = 22;
`endif

  always #5 clk = ~clk;

  aes dut (
    .clk  (clk),
    .reset(reset),
    .sck  (sck),
    .sdi  (sdi),
    .load (load),
    .sdo  (sdo),
    .done (done)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic shift_in(input logic [127:0] ct, input logic [127:0] key);
    logic [255:0] v;
    v = {ct, key};
    load = 1'b1;
    for (int i = 255; i >= 0; i--) begin
      sdi = v[i];
      #7 sck = 1'b1;
      #7 sck = 1'b0;
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 100);
  endtask

  task automatic finish_vector(input string tag, input logic [127:0] pt);
    int n;
    logic [127:0] got;
    wait_done(n);
    check({tag, " latency"}, 128'(n), 128'(Latency));
    check({tag, " sdo msb"}, 128'(sdo), 128'(pt[127]));
    for (int i = 127; i >= 0; i--) begin
      #7 got[i] = sdo;
      sck = 1'b1;
      #7 sck = 1'b0;
    end
    #2;
    check({tag, " plaintext"}, got, pt);
    check({tag, " done held"}, 128'(done), 128'(1'b1));
    check({tag, " zero fill"}, 128'(sdo), 128'(1'b0));
  endtask

  initial begin
    reset = 1'b1;
    sck   = 1'b0;
    sdi   = 1'b0;
    load  = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset done", 128'(done), 128'(1'b0));
    check("reset sdo", 128'(sdo), 128'(1'b0));
    reset = 1'b1;

    // Load low with no prior load pulse must not start.
    repeat (30) @(posedge clk);
    #1 check("idle no start", 128'(done), 128'(1'b0));

    shift_in(Ct1, Key1);
    finish_vector("vec1", Pt1);

    // Back-to-back: done drops as soon as load rises.
    @(negedge clk);
    load = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("b2b done drop", 128'(done), 128'(1'b0));
    shift_in(Ct2, Key2);
    finish_vector("vec2", Pt2);

    // Reset five cycles into decrypt.
    shift_in(Ct1, Key1);
    repeat (16) @(posedge clk);
    #3 reset = 1'b0;
    #1 check("mid reset done", 128'(done), 128'(1'b0));
    check("mid reset sdo", 128'(sdo), 128'(1'b0));
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1 check("post reset idle", 128'(done), 128'(1'b0));
    shift_in(Ct1, Key1);
    finish_vector("rerun", Pt1);

    // Reset while unloading clears a set sdo (Pt1 bit 125 is one).
    shift_in(Ct1, Key1);
    begin
      int n;
      wait_done(n);
    end
    repeat (2) begin
      #7 sck = 1'b1;
      #7 sck = 1'b0;
    end
    #1 check("unload bit125", 128'(sdo), 128'(1'b1));
    reset = 1'b0;
    #1 check("done reset sdo", 128'(sdo), 128'(1'b0));
    check("done reset done", 128'(done), 128'(1'b0));
    @(negedge clk);
    reset = 1'b1;

    // Abort during decrypt with a new vector.
    shift_in(Ct1, Key1);
    repeat (15) @(posedge clk);
    shift_in(Ct2, Key2);
    finish_vector("abort", Pt2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
